// File: rtl/mips_pkg.sv
// mips_pkg: shared MIPS pipeline types and memory stage defaults
package mips_pkg;
  typedef enum logic {IDLE, BUSY} mem_state_e;
  localparam int MEM_DEPTH   = 64;
  localparam int MEM_LATENCY = 2;
endpackage

// File: rtl/data_ram.sv
// data_ram: word-addressed data memory, synchronous write, combinational read, never reset
module data_ram #(
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_addr,
  input  logic [31:0]              i_wdata,
  output logic [31:0]              o_rdata
);
  logic [31:0] r_mem [DEPTH];
  always_ff @(posedge clk)
    if (i_we) r_mem[i_addr] <= i_wdata;
  assign o_rdata = r_mem[i_addr];
endmodule

// File: rtl/memory_stage.sv
// memory_stage: MIPS MEM stage with multi-cycle data RAM access and pass-through writeback
module memory_stage
  import mips_pkg::*;
#(
  parameter int DEPTH   = MEM_DEPTH,
  parameter int LATENCY = MEM_LATENCY
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_in,
  input  logic [31:0] ALU_result,
  input  logic [31:0] write_data,
  input  logic [4:0]  rd,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        MemtoReg,
  input  logic        RegWrite,
  output logic        stall,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd,
  output logic        wb_RegWrite,
  output logic        misaligned
);
  localparam int AW = $clog2(DEPTH);
  mem_state_e  r_state, w_state_nx;
  logic [3:0]  r_cnt, w_cnt_nx;
  logic        w_accept, w_mem, w_mis, w_start, w_done;
  logic [31:0] r_addr, r_wdata, w_rdata;
  logic [4:0]  r_rd;
  logic        r_store, r_memtoreg, r_regwrite;

  always_comb begin
    w_accept   = valid_in && r_state == IDLE;
    w_mem      = MemRead || MemWrite;
    w_mis      = w_mem && |ALU_result[1:0];
    w_start    = w_accept && w_mem && !w_mis;
    w_done     = r_state == BUSY && r_cnt == 4'd0;
    w_state_nx = w_start ? BUSY : w_done ? IDLE : r_state;
    w_cnt_nx   = w_start ? 4'(LATENCY - 1) : (r_state == BUSY && r_cnt != 4'd0) ? r_cnt - 4'd1 : r_cnt;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
    end

  // MemRead with MemWrite is a store
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rd       <= '0;
      r_store    <= 1'b0;
      r_memtoreg <= 1'b0;
      r_regwrite <= 1'b0;
    end else if (w_start) begin
      r_addr     <= ALU_result;
      r_wdata    <= write_data;
      r_rd       <= rd;
      r_store    <= MemWrite;
      r_memtoreg <= MemtoReg;
      r_regwrite <= RegWrite;
    end

  data_ram #(.DEPTH(DEPTH)) u_ram (
    .clk     (clk),
    .i_we    (w_done && r_store),
    .i_addr  (r_addr[AW+1:2]),
    .i_wdata (r_wdata),
    .o_rdata (w_rdata)
  );

  assign stall = r_state == BUSY;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wb_valid    <= 1'b0;
      wb_data     <= '0;
      wb_rd       <= '0;
      wb_RegWrite <= 1'b0;
      misaligned  <= 1'b0;
    end else begin
      wb_valid   <= 1'b0;
      misaligned <= 1'b0;
      if (w_done) begin
        wb_valid    <= 1'b1;
        wb_data     <= r_store ? r_wdata : r_memtoreg ? w_rdata : r_addr;
        wb_rd       <= r_rd;
        wb_RegWrite <= !r_store && r_regwrite;
      end else if (w_accept && !w_start) begin
        wb_valid    <= 1'b1;
        misaligned  <= w_mis;
        wb_data     <= ALU_result;
        wb_rd       <= rd;
        wb_RegWrite <= RegWrite && !w_mis;
      end
    end
endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: directed self-checking bench for memory_stage
module tb_memory_stage;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        valid_in = 1'b0;
  logic [31:0] ALU_result = '0;
  logic [31:0] write_data = '0;
  logic [4:0]  rd = '0;
  logic        MemRead = 1'b0, MemWrite = 1'b0, MemtoReg = 1'b0, RegWrite = 1'b0;
  logic        stall, wb_valid, wb_RegWrite, misaligned;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  int          n_chk = 0;
  int          n_err = 0;

  memory_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .valid_in    (valid_in),
    .ALU_result  (ALU_result),
    .write_data  (write_data),
    .rd          (rd),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .MemtoReg    (MemtoReg),
    .RegWrite    (RegWrite),
    .stall       (stall),
    .wb_valid    (wb_valid),
    .wb_data     (wb_data),
    .wb_rd       (wb_rd),
    .wb_RegWrite (wb_RegWrite),
    .misaligned  (misaligned)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] wd, input logic [4:0] r,
                       input logic mr, input logic mw, input logic m2r, input logic rw);
    valid_in = v; ALU_result = a; write_data = wd; rd = r;
    MemRead = mr; MemWrite = mw; MemtoReg = m2r; RegWrite = rw;
  endtask

  task automatic mem_op(input string tag, input logic [31:0] a, input logic [31:0] wd, input logic [4:0] r,
                        input logic mr, input logic mw, input logic m2r, input logic rw,
                        input logic [31:0] exp_data, input logic exp_rw);
    int stalls = 0;
    int n = 0;
    drive(1'b1, a, wd, r, mr, mw, m2r, rw);
    step();
    valid_in = 1'b0;
    while (!wb_valid && n < 20) begin
      stalls += int'(stall);
      n++;
      step();
    end
    chk({tag, "_stalls"}, stalls, 2);
    chk({tag, "_valid"}, wb_valid, 1);
    chk({tag, "_data"}, wb_data, exp_data);
    chk({tag, "_regwrite"}, wb_RegWrite, exp_rw);
    chk({tag, "_rd"}, wb_rd, r);
    chk({tag, "_stall_done"}, stall, 0);
    step();
    chk({tag, "_pulse"}, wb_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int pulses;
    logic [31:0] got;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_stall", stall, 0);
    chk("rst_valid", wb_valid, 0);
    chk("rst_data", wb_data, 0);
    chk("rst_rd", wb_rd, 0);
    chk("rst_regwrite", wb_RegWrite, 0);
    chk("rst_mis", misaligned, 0);
    step();
    step();
    rst_n = 1'b1;

    drive(1'b1, 32'd12, 32'd0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    chk("alu_valid", wb_valid, 1);
    chk("alu_data", wb_data, 12);
    chk("alu_rd", wb_rd, 3);
    chk("alu_regwrite", wb_RegWrite, 1);
    chk("alu_stall", stall, 0);
    valid_in = 1'b0;
    step();
    chk("alu_pulse", wb_valid, 0);

    mem_op("st12", 32'd12, 32'hDEADBEEF, 5'd5, 1'b0, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0);
    mem_op("ld12", 32'd12, 32'd0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1, 32'hDEADBEEF, 1'b1);
    mem_op("st268", 32'd268, 32'h12345678, 5'd6, 1'b1, 1'b1, 1'b1, 1'b1, 32'h12345678, 1'b0);
    mem_op("ld_wrap", 32'd12, 32'd0, 5'd8, 1'b1, 1'b0, 1'b1, 1'b1, 32'h12345678, 1'b1);
    mem_op("ld_addr", 32'd12, 32'd0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b1, 32'd12, 1'b1);

    drive(1'b1, 32'd13, 32'd0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1);
    step();
    chk("mis_flag", misaligned, 1);
    chk("mis_valid", wb_valid, 1);
    chk("mis_regwrite", wb_RegWrite, 0);
    chk("mis_stall", stall, 0);
    chk("mis_rd", wb_rd, 9);
    valid_in = 1'b0;
    step();
    chk("mis_pulse", misaligned, 0);
    chk("mis_valid_pulse", wb_valid, 0);

    mem_op("st20", 32'd20, 32'h11112222, 5'd2, 1'b0, 1'b1, 1'b0, 1'b0, 32'h11112222, 1'b0);
    drive(1'b1, 32'd20, 32'hA5A5A5A5, 5'd2, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    valid_in = 1'b0;
    chk("abort_busy", stall, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_stall", stall, 0);
    chk("abort_valid", wb_valid, 0);
    chk("abort_data", wb_data, 0);
    chk("abort_rd", wb_rd, 0);
    chk("abort_regwrite", wb_RegWrite, 0);
    chk("abort_mis", misaligned, 0);
    step();
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      pulses += int'(wb_valid);
    end
    chk("abort_no_pulse", pulses, 0);
    mem_op("ld20", 32'd20, 32'd0, 5'd11, 1'b1, 1'b0, 1'b1, 1'b1, 32'h11112222, 1'b1);

    drive(1'b1, 32'd12, 32'd0, 5'd12, 1'b1, 1'b0, 1'b1, 1'b1);
    pulses = 0;
    got = '0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (wb_valid) begin
        pulses++;
        got = wb_data;
      end
      if (i < 2) ALU_result = 32'd40 + 32'(4 * i);
      if (i == 2) valid_in = 1'b0;
    end
    chk("hold_pulses", pulses, 1);
    chk("hold_data", got, 32'h12345678);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
